// File: rtl/i2s_pkg.sv
// Shared constants, sample-pair type and helpers for the I2S transmitter.
package i2s_pkg;

  localparam int I2S_DATA_WIDTH = 24;
  localparam int I2S_SLOT_WIDTH = 32;

  typedef struct packed {
    logic signed [I2S_DATA_WIDTH-1:0] left;
    logic signed [I2S_DATA_WIDTH-1:0] right;
  } stereo_sample_t;

  // Increment a 16-bit status counter, sticking at all-ones.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    logic [15:0] result;
    if (value == 16'hFFFF) begin
      result = value;
    end else begin
      result = value + 16'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/i2s_piso.sv
// Parallel-in serial-out frame shifter; sdata always mirrors the current MSB.
module i2s_piso
  import i2s_pkg::*;
#(
  parameter int WIDTH = 2 * I2S_SLOT_WIDTH
) (
  input  logic             clk_12_288,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] frame,
  output logic             sdata
);

  logic [WIDTH-1:0] shift_r;
  logic             sdata_r;

  // Load a new frame or shift out one bit per sclk, MSB first.
  always_ff @(posedge clk_12_288) begin
    if (reset) begin
      shift_r <= '0;
      sdata_r <= 1'b0;
    end else if (load) begin
      shift_r <= frame;
      sdata_r <= frame[WIDTH-1];
    end else if (shift) begin
      shift_r <= {shift_r[WIDTH-2:0], 1'b0};
      sdata_r <= shift_r[WIDTH-2];
    end else begin
      shift_r <= shift_r;
      sdata_r <= sdata_r;
    end
  end

  assign sdata = sdata_r;

endmodule

// File: rtl/i2s_tx.sv
// Stereo I2S transmitter: one-deep pending pair, frame loader and status flags.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH = I2S_DATA_WIDTH,
  parameter int SLOT_WIDTH = I2S_SLOT_WIDTH
) (
  input  logic                  clk_12_288,
  input  logic                  reset,
  input  logic                  sclk,
  input  logic                  lrclk,
  input  logic                  rd_en,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_left,
  input  logic [DATA_WIDTH-1:0] in_right,
  output logic                  sdata,
  output logic                  underrun,
  output logic [15:0]           underrun_count,
  output logic                  sync_err
);

  localparam int FRAME_WIDTH = 2 * SLOT_WIDTH;

  logic                   load_s;
  logic                   shift_s;
  logic                   ready_s;
  logic                   accept_s;
  logic [FRAME_WIDTH-1:0] frame_s;

  logic                   pending_valid_r;
  logic [DATA_WIDTH-1:0]  pending_left_r;
  logic [DATA_WIDTH-1:0]  pending_right_r;
  logic                   underrun_r;
  logic [15:0]            underrun_count_r;
  logic                   sync_err_r;

  // Each word sits at the top of its slot; the unused slot tail is zero.
  function automatic logic [FRAME_WIDTH-1:0] build_frame(
    input logic [DATA_WIDTH-1:0] left,
    input logic [DATA_WIDTH-1:0] right
  );
    logic [FRAME_WIDTH-1:0] f;
    f = '0;
    f[FRAME_WIDTH-1 -: DATA_WIDTH] = left;
    f[SLOT_WIDTH-1  -: DATA_WIDTH] = right;
    return f;
  endfunction

  // Decode divider strobes, the input handshake and the frame to load.
  always_comb begin
    load_s   = rd_en;
    shift_s  = sclk & ~rd_en;
    ready_s  = ~reset & (~pending_valid_r | rd_en);
    accept_s = in_valid & ready_s;
    frame_s  = '0;
    if (pending_valid_r) begin
      frame_s = build_frame(pending_left_r, pending_right_r);
    end else begin
      frame_s = '0;
    end
  end

  // Pending pair: captured on accept, released to the shifter on load.
  always_ff @(posedge clk_12_288) begin
    if (reset) begin
      pending_valid_r <= 1'b0;
      pending_left_r  <= '0;
      pending_right_r <= '0;
    end else if (accept_s) begin
      pending_valid_r <= 1'b1;
      pending_left_r  <= in_left;
      pending_right_r <= in_right;
    end else if (load_s) begin
      pending_valid_r <= 1'b0;
      pending_left_r  <= pending_left_r;
      pending_right_r <= pending_right_r;
    end else begin
      pending_valid_r <= pending_valid_r;
      pending_left_r  <= pending_left_r;
      pending_right_r <= pending_right_r;
    end
  end

  // Status flags: underrun / sync error pulses and saturating underrun count.
  always_ff @(posedge clk_12_288) begin
    if (reset) begin
      underrun_r       <= 1'b0;
      underrun_count_r <= 16'd0;
      sync_err_r       <= 1'b0;
    end else begin
      underrun_r <= load_s & ~pending_valid_r;
      sync_err_r <= load_s & lrclk;
      if (load_s && !pending_valid_r) begin
        underrun_count_r <= sat_inc16(underrun_count_r);
      end else begin
        underrun_count_r <= underrun_count_r;
      end
    end
  end

  i2s_piso #(
    .WIDTH(FRAME_WIDTH)
  ) u_piso (
    .clk_12_288(clk_12_288),
    .reset     (reset),
    .load      (load_s),
    .shift     (shift_s),
    .frame     (frame_s),
    .sdata     (sdata)
  );

  assign in_ready       = ready_s;
  assign underrun       = underrun_r;
  assign underrun_count = underrun_count_r;
  assign sync_err       = sync_err_r;

endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx: directed frame table, corner sequences, random stream.
module tb_i2s_tx;
  import i2s_pkg::*;

  localparam int DW = I2S_DATA_WIDTH;
  localparam int SW = I2S_SLOT_WIDTH;
  localparam int FW = 2 * SW;

  logic          clk_12_288 = 1'b0;
  logic          reset, sclk, lrclk, rd_en, in_valid, in_ready;
  logic [DW-1:0] in_left, in_right;
  logic          sdata, underrun, sync_err;
  logic [15:0]   underrun_count;

  always #5 clk_12_288 = ~clk_12_288;

  i2s_tx dut (
    .clk_12_288    (clk_12_288),
    .reset         (reset),
    .sclk          (sclk),
    .lrclk         (lrclk),
    .rd_en         (rd_en),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_left       (in_left),
    .in_right      (in_right),
    .sdata         (sdata),
    .underrun      (underrun),
    .underrun_count(underrun_count),
    .sync_err      (sync_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // divider phase (128 mclk per frame) and stimulus state
  logic [6:0]     cnt = 7'd2;
  logic           rst_s = 1'b1, v_s = 1'b0, inj_s = 1'b0;
  logic           chk_sdata = 1'b1, cap_en = 1'b0;
  int             mode = 0;  // 0 one-shot, 1 incrementing stream, 2 random
  logic [DW-1:0]  sl = '0, sr = '0;

  // reference model
  stereo_sample_t q[$];
  logic [FW-1:0]  cur_frame = '0;
  logic [FW-1:0]  cap_word = '0;
  logic           exp_ur = 1'b0, exp_sync = 1'b0, exp_ready;
  logic [15:0]    exp_cnt = 16'd0;
  int             ur_seen = 0, sync_seen = 0;

  typedef struct {
    logic          send;
    logic [DW-1:0] l;
    logic [DW-1:0] r;
    logic [FW-1:0] frame;
    int            urs;
  } vec_t;
  vec_t tbl[4];

  function automatic logic [FW-1:0] ref_frame(stereo_sample_t p);
    logic [FW-1:0] lw, rw;
    lw = {{(FW-DW){1'b0}}, p.left};
    rw = {{(FW-DW){1'b0}}, p.right};
    return (lw << (FW - DW)) | (rw << (SW - DW));
  endfunction

  // Bit of the current frame the DAC should see in this phase of the frame.
  function automatic logic exp_sdata();
    int c;
    c = int'(cnt);
    if (c >= 2) return cur_frame[FW - 1 - ((c - 2) / 2)];
    else        return cur_frame[0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One master-clock cycle: drive at negedge, check, advance model at posedge.
  task automatic step();
    stereo_sample_t p;
    logic           acc;
    logic [31:0]    rnd;
    int             c;
    if (mode == 2) begin
      rnd = $urandom; sl = rnd[DW-1:0];
      rnd = $urandom; sr = rnd[DW-1:0];
      v_s = ($urandom_range(0, 2) != 0);
    end
    sclk = cnt[0]; lrclk = cnt[6]; rd_en = (cnt == 7'd1) | inj_s;
    reset = rst_s; in_valid = v_s; in_left = sl; in_right = sr;
    #1;
    exp_ready = !rst_s && (q.size() == 0 || rd_en);
    check("in_ready", in_ready, exp_ready);
    if (chk_sdata) check("sdata", sdata, exp_sdata());
    check("underrun", underrun, exp_ur);
    check("underrun_count", underrun_count, exp_cnt);
    check("sync_err", sync_err, exp_sync);
    ur_seen   += int'(underrun);
    sync_seen += int'(sync_err);
    c = int'(cnt);
    if (cap_en && sclk) begin
      if (c >= 3) cap_word[FW - 1 - (c - 3) / 2] = sdata;
      else        cap_word[0] = sdata;
    end
    @(posedge clk_12_288);
    if (rst_s) begin
      q.delete();
      cur_frame = '0; exp_ur = 1'b0; exp_sync = 1'b0; exp_cnt = 16'd0;
    end else begin
      acc = v_s && exp_ready;
      exp_ur = 1'b0; exp_sync = 1'b0;
      if (rd_en) begin
        exp_sync = lrclk;
        if (q.size() != 0) begin
          p = q.pop_front();
          cur_frame = ref_frame(p);
        end else begin
          cur_frame = '0;
          exp_ur = 1'b1;
          if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        end
      end
      if (acc) begin
        p.left = sl; p.right = sr;
        q.push_back(p);
        if (mode == 0) v_s = 1'b0;
        else if (mode == 1) begin sl = sl + 24'd1; sr = sr + 24'd1; end
      end
    end
    cnt = cnt + 7'd1;
    @(negedge clk_12_288);
  endtask

  task automatic run_to(input logic [6:0] t);
    while (cnt != t) step();
  endtask

  // Pass exactly one frame load and stop just after it (cnt == 2).
  task automatic next_frame();
    step();
    run_to(7'd2);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{1'b1, 24'hA5A5A5, 24'h3C3C3C, 64'hA5A5A500_3C3C3C00, 0};
    tbl[1] = '{1'b1, 24'h800000, 24'h7FFFFF, 64'h80000000_7FFFFF00, 0};
    tbl[2] = '{1'b1, 24'hFFFFFF, 24'h000001, 64'hFFFFFF00_00000100, 0};
    tbl[3] = '{1'b0, 24'h123456, 24'h654321, 64'h00000000_00000000, 1};

    reset = 1'b1; sclk = 1'b0; lrclk = 1'b0; rd_en = 1'b0;
    in_valid = 1'b0; in_left = '0; in_right = '0;
    @(posedge clk_12_288);
    @(negedge clk_12_288);
    repeat (2) step();
    rst_s = 1'b0;

    // directed frames: first entry goes out on the very first rd_en
    for (int i = 0; i < 4; i++) begin
      mode = 0; sl = tbl[i].l; sr = tbl[i].r; v_s = tbl[i].send;
      next_frame();
      ur_seen = 0; cap_word = '0; cap_en = 1'b1;
      repeat (128) step();
      cap_en = 1'b0;
      check($sformatf("frame_bits[%0d]", i), cap_word, tbl[i].frame);
      check($sformatf("frame_underruns[%0d]", i), ur_seen, tbl[i].urs);
    end

    // three silent frames after reset
    rst_s = 1'b1; repeat (2) step(); rst_s = 1'b0;
    v_s = 1'b0; ur_seen = 0;
    repeat (3) next_frame();
    step();
    check("silent_underruns", ur_seen, 3);
    check("silent_count", underrun_count, 16'd3);

    // continuous incrementing stream over 10 frames
    mode = 1; sl = 24'h000100; sr = 24'h800100; v_s = 1'b1;
    repeat (10 * 128) step();
    check("stream_pairs_sent", sl, 24'h000100 + 24'd11);
    mode = 0; v_s = 1'b0;
    next_frame();

    // saturation from FFFE
    force dut.underrun_count_r = 16'hFFFE;
    #1;
    release dut.underrun_count_r;
    exp_cnt = 16'hFFFE;
    repeat (3) next_frame();
    step();
    check("count_saturated", underrun_count, 16'hFFFF);

    // rd_en while lrclk = 1
    next_frame();
    mode = 0; sl = 24'hC00001; sr = 24'h00000F; v_s = 1'b1;
    run_to(7'd80);
    chk_sdata = 1'b0; sync_seen = 0; ur_seen = 0;
    inj_s = 1'b1; step(); inj_s = 1'b0;
    check("sync_load_msb", sdata, 1'b1);
    repeat (3) step();
    check("sync_pulses", sync_seen, 1);
    check("sync_no_underrun", ur_seen, 0);
    rst_s = 1'b1; repeat (2) step(); rst_s = 1'b0;
    chk_sdata = 1'b1;

    // reset in the middle of the right slot with a pair pending
    next_frame();
    mode = 0; sl = 24'h5A5A5A; sr = 24'h123456; v_s = 1'b1;
    run_to(7'd90);
    rst_s = 1'b1; step();
    check("rst_sdata", sdata, 1'b0);
    check("rst_ready", in_ready, 1'b0);
    step();
    rst_s = 1'b0; v_s = 1'b0; ur_seen = 0;
    run_to(7'd3);
    check("rst_then_underrun", ur_seen, 1);

    // randomized traffic against the model
    mode = 2;
    repeat (20 * 128) step();
    mode = 0; v_s = 1'b0;
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
